// File: rtl/intersection_scheduler.sv
// intersection_scheduler: two-approach signal controller with left arrows, pedestrian walks and green truncation.
// Define EMERGENCY_PREEMPT_EN to add emergency preemption (PRE all-red hold); otherwise emergency is ignored.
module intersection_scheduler #(
  parameter int GREEN_T   = 20,
  parameter int YELLOW_T  = 2,
  parameter int LEFT_T    = 10,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 14,
  parameter int FLASH_T   = 6,
  parameter int MIN_GREEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  input  logic       emergency,
  output logic [3:0] car_ns,
  output logic [3:0] car_ew,
  output logic [1:0] walk_ns,
  output logic [1:0] walk_ew,
  output logic [1:0] ped_wait
);
  typedef enum logic [3:0] {NS_G, NS_Y1, NS_L, NS_Y2, AR1, EW_G, EW_Y1, EW_L, EW_Y2, AR2
`ifdef EMERGENCY_PREEMPT_EN
    , PRE
`endif
  } phase_t;
  localparam logic [7:0] WALK_END  = 8'(WALK_T);
  localparam logic [7:0] FLASH_END = 8'(WALK_T + FLASH_T);
  localparam logic [7:0] WALK_DONE = 8'(WALK_T + FLASH_T - 1);
  localparam logic [7:0] TRUNC_AT  = 8'(MIN_GREEN - 1);
  phase_t phase, nxt;
  logic [7:0] timer, dur;
  logic [1:0] walk;
  logic lat_ns, lat_ew, served, green, left, ns_side, trunc, go, enter_ns, enter_ew;
`ifndef EMERGENCY_PREEMPT_EN
  logic unused;
  assign unused = emergency;
`endif
  always_comb begin
    green = phase == NS_G || phase == EW_G;
    left = phase == NS_L || phase == EW_L;
    ns_side = phase inside {NS_G, NS_Y1, NS_L, NS_Y2};
    dur = green ? 8'(GREEN_T) : left ? 8'(LEFT_T) : (phase inside {AR1, AR2}) ? 8'(ALLRED_T) : 8'(YELLOW_T);
    // a served walk must finish its flash before the opposing request may cut green short
    trunc = green && (ns_side ? lat_ew : lat_ns) && timer >= TRUNC_AT && (!served || timer >= WALK_DONE);
`ifdef EMERGENCY_PREEMPT_EN
    go = phase == PRE ? !emergency : (emergency && (green || left)) || timer == dur - 8'd1 || trunc;
    nxt = phase == PRE ? AR2 :
          (emergency && (green || left)) ? (ns_side ? NS_Y2 : EW_Y2) :
          emergency ? PRE :
          phase == AR2 ? NS_G : phase_t'(phase + 4'd1);
`else
    go = timer == dur - 8'd1 || trunc;
    nxt = phase == AR2 ? NS_G : phase_t'(phase + 4'd1);
`endif
    enter_ns = tick && go && nxt == NS_G;
    enter_ew = tick && go && nxt == EW_G;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= NS_G;
      timer <= '0;
      lat_ns <= 1'b0;
      lat_ew <= 1'b0;
      served <= 1'b0;
    end else begin
      if (tick && go) begin
        phase <= nxt;
        timer <= '0;
        served <= enter_ns ? (lat_ns || ped_req_ns) : enter_ew ? (lat_ew || ped_req_ew) : 1'b0;
      end else if (tick) timer <= timer + 8'd1;
      lat_ns <= !enter_ns && (lat_ns || ped_req_ns);
      lat_ew <= !enter_ew && (lat_ew || ped_req_ew);
    end
  end
  always_comb begin
    car_ns = phase == NS_G ? 4'b0001 : (phase inside {NS_Y1, NS_Y2}) ? 4'b0100 : phase == NS_L ? 4'b0010 : 4'b1000;
    car_ew = phase == EW_G ? 4'b0001 : (phase inside {EW_Y1, EW_Y2}) ? 4'b0100 : phase == EW_L ? 4'b0010 : 4'b1000;
    walk = timer < WALK_END ? 2'b01 : timer < FLASH_END ? {1'b0, ~timer[0]} : 2'b10;
    walk_ns = (phase == NS_G && served) ? walk : 2'b10;
    walk_ew = (phase == EW_G && served) ? walk : 2'b10;
    ped_wait = {lat_ew, lat_ns};
  end
endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: table of cycle-plan checkpoints plus hand-written request, freeze, reset and emergency sequences.
module tb_intersection_scheduler;
  logic clk = 1'b0;
  logic rst, tick, ped_req_ns, ped_req_ew, emergency;
  logic [3:0] car_ns, car_ew;
  logic [1:0] walk_ns, walk_ew, ped_wait;
  int checks = 0, errors = 0, k = 0;
  localparam logic [3:0] R = 4'b1000, Y = 4'b0100, L = 4'b0010, G = 4'b0001;
  localparam logic [1:0] WR = 2'b10, WG = 2'b01, WO = 2'b00;
  typedef struct {
    int id;
    int k;
    logic [13:0] exp;
  } vec_t;
  vec_t q[$];
  vec_t tbl[16];

  intersection_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
    .emergency(emergency), .car_ns(car_ns), .car_ew(car_ew), .walk_ns(walk_ns),
    .walk_ew(walk_ew), .ped_wait(ped_wait)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] pk(input logic [3:0] cn, input logic [3:0] ce,
                                     input logic [1:0] wn, input logic [1:0] we, input logic [1:0] pw);
    return {cn, ce, wn, we, pw};
  endfunction

  task automatic step(input logic r, input logic t, input logic pn, input logic pe, input logic em);
    rst = r; tick = t; ped_req_ns = pn; ped_req_ew = pe; emergency = em;
    @(posedge clk);
    @(negedge clk);
    if (r) k = 0;
    else if (t) k++;
    checks++;
    if (car_ns != R && car_ew != R) begin
      errors++;
      $display("FAIL safety k=%0d car_ns=%b car_ew=%b (one must be 1000)", k, car_ns, car_ew);
    end
  endtask

  task automatic adv(input int target);
    while (k < target) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_step(input int id, input logic r, input logic t, input logic pn,
                             input logic pe, input logic em, input logic [13:0] exp);
    vec_t e;
    logic [13:0] got;
    q.push_back('{id, k, exp});
    step(r, t, pn, pe, em);
    e = q.pop_front();
    got = {car_ns, car_ew, walk_ns, walk_ew, ped_wait};
    checks++;
    if (got !== e.exp) begin
      errors++;
      $display("FAIL vec%0d k=%0d got cn/ce/wn/we/pw=%b required=%b", e.id, k, got, e.exp);
    end
  endtask

  initial begin
    tbl[0]  = '{0, 19, pk(G, R, WR, WR, 2'b00)};
    tbl[1]  = '{1, 20, pk(Y, R, WR, WR, 2'b00)};
    tbl[2]  = '{2, 21, pk(Y, R, WR, WR, 2'b00)};
    tbl[3]  = '{3, 22, pk(L, R, WR, WR, 2'b00)};
    tbl[4]  = '{4, 31, pk(L, R, WR, WR, 2'b00)};
    tbl[5]  = '{5, 32, pk(Y, R, WR, WR, 2'b00)};
    tbl[6]  = '{6, 34, pk(R, R, WR, WR, 2'b00)};
    tbl[7]  = '{7, 35, pk(R, R, WR, WR, 2'b00)};
    tbl[8]  = '{8, 36, pk(R, G, WR, WR, 2'b00)};
    tbl[9]  = '{9, 55, pk(R, G, WR, WR, 2'b00)};
    tbl[10] = '{10, 56, pk(R, Y, WR, WR, 2'b00)};
    tbl[11] = '{11, 58, pk(R, L, WR, WR, 2'b00)};
    tbl[12] = '{12, 68, pk(R, Y, WR, WR, 2'b00)};
    tbl[13] = '{13, 70, pk(R, R, WR, WR, 2'b00)};
    tbl[14] = '{14, 72, pk(G, R, WR, WR, 2'b00)};
    tbl[15] = '{15, 92, pk(Y, R, WR, WR, 2'b00)};
    rst = 1'b1; tick = 1'b0; ped_req_ns = 1'b0; ped_req_ew = 1'b0; emergency = 1'b0;
    @(negedge clk);
    // free-running cycle with no requests
    expect_step(99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pk(G, R, WR, WR, 2'b00));
    for (int i = 0; i < 16; i++) begin
      adv(tbl[i].k - 1);
      expect_step(tbl[i].id, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, tbl[i].exp);
    end
    // EW request truncates NS green at timer 7, then EW walk with flash
    expect_step(100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pk(G, R, WR, WR, 2'b00));
    adv(3);
    expect_step(101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, pk(G, R, WR, WR, 2'b10));
    adv(7);
    expect_step(102, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(Y, R, WR, WR, 2'b10));
    adv(23);
    expect_step(103, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(R, G, WR, WG, 2'b00));
    adv(36);
    expect_step(104, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(R, G, WR, WG, 2'b00));
    expect_step(105, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(R, G, WR, WG, 2'b00));
    expect_step(106, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(R, G, WR, WO, 2'b00));
    expect_step(107, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(R, G, WR, WG, 2'b00));
    adv(42);
    expect_step(108, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(R, G, WR, WO, 2'b00));
    expect_step(109, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(R, Y, WR, WR, 2'b00));
    // NS request in the AR2->NS_G entry cycle is served at once; served walk blocks truncation
    expect_step(200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pk(G, R, WR, WR, 2'b00));
    adv(71);
    expect_step(201, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pk(G, R, WG, WR, 2'b00));
    adv(75);
    expect_step(202, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, pk(G, R, WG, WR, 2'b10));
    adv(79);
    expect_step(203, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(G, R, WG, WR, 2'b10));
    adv(86);
    expect_step(204, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(G, R, WO, WR, 2'b10));
    adv(91);
    expect_step(205, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(Y, R, WR, WR, 2'b10));
    // tick frozen mid NS_L; a request still latches
    expect_step(300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pk(G, R, WR, WR, 2'b00));
    adv(25);
    for (int i = 0; i < 49; i++) step(1'b0, 1'b0, 1'b0, i == 10, 1'b0);
    expect_step(301, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pk(L, R, WR, WR, 2'b10));
    adv(30);
    expect_step(302, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(L, R, WR, WR, 2'b10));
    expect_step(303, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(Y, R, WR, WR, 2'b10));
    // reset during EW_L abandons the phase and clears latches
    expect_step(400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pk(G, R, WR, WR, 2'b00));
    adv(59);
    expect_step(401, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pk(R, L, WR, WR, 2'b01));
    expect_step(402, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pk(G, R, WR, WR, 2'b00));
    expect_step(403, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(G, R, WR, WR, 2'b00));
    expect_step(500, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pk(G, R, WR, WR, 2'b00));
    adv(41);
`ifdef EMERGENCY_PREEMPT_EN
    expect_step(501, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, pk(R, Y, WR, WR, 2'b00));
    expect_step(502, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, pk(R, Y, WR, WR, 2'b00));
    expect_step(503, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, pk(R, R, WR, WR, 2'b00));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_step(504, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, pk(R, R, WR, WR, 2'b00));
    expect_step(505, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(R, R, WR, WR, 2'b00));
    expect_step(506, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(R, R, WR, WR, 2'b00));
    expect_step(507, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(G, R, WR, WR, 2'b00));
`else
    expect_step(501, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, pk(R, G, WR, WR, 2'b00));
    expect_step(502, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, pk(R, G, WR, WR, 2'b00));
    adv(55);
    expect_step(503, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, pk(R, Y, WR, WR, 2'b00));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 Parameters (name, default, meaning): GREEN_T 20 straight-green ticks; YELLOW_T 2 yellow ticks; LEFT_T 10 left-arrow ticks; ALLRED_T 2 all-red clearance ticks; WALK_T 14 steady walk ticks; FLASH_T 6 flashing walk ticks; MIN_GREEN 8 ticks before a ped request may truncate green.
REQ-002 Port clk, input, 1: single clock; all state changes on posedge clk.
REQ-003 Port rst, input, 1: synchronous reset, active-high.
REQ-004 Port tick, input, 1: one-cycle timebase enable; all timers advance only when tick=1.
REQ-005 Port ped_req_ns / ped_req_ew, input, 1 each: pedestrian pushbuttons for the crossing parallel to NS / EW traffic.
REQ-006 Port emergency, input, 1: preemption request (used only under REQ-026).
REQ-007 Port car_ns / car_ew, output, 4 each: one-hot lamps RED=1000, YELLOW=0100, LEFT=0010, GREEN=0001.
REQ-008 Port walk_ns / walk_ew, output, 2 each: RED=10, GREEN=01, OFF=00.
REQ-009 Port ped_wait, output, 2: [1]=EW, [0]=NS request latched and not yet served.

Function
REQ-010 Phase FSM SHALL cycle NS_G -> NS_Y1 -> NS_L -> NS_Y2 -> AR1 -> EW_G -> EW_Y1 -> EW_L -> EW_Y2 -> AR2 -> NS_G.
REQ-011 Phase timer SHALL count ticks from 0, clear on every phase entry, and the phase SHALL exit on the tick where timer = duration-1 (G=GREEN_T, Y1/Y2=YELLOW_T, L=LEFT_T, AR=ALLRED_T).
REQ-012 Lamps: in X_G car_X=GREEN, X_Y1/X_Y2 car_X=YELLOW, X_L car_X=LEFT; the other approach and both approaches in AR1/AR2 show RED; never two non-RED car outputs simultaneously.
REQ-013 Ped latch X SHALL set when ped_req_X=1 and clear on entry to X_G; a request asserted in the entry cycle SHALL count as served (latch stays 0, walk served).
REQ-014 ped_wait SHALL equal the latches, registered, no additional latency.
REQ-015 On X_G entry with request served, walk_X SHALL be GREEN for timer 0..WALK_T-1, then for timer WALK_T..WALK_T+FLASH_T-1 alternate OFF (odd timer) / GREEN (even timer), then RED.
REQ-016 walk_X SHALL be RED in every phase other than X_G and throughout X_G when no request was served.
REQ-017 While in Y_G (opposing green) with latch X set and timer >= MIN_GREEN-1, the phase SHALL exit to Y_Y1 on the next tick (green truncation); truncation never applies to Y, L or AR phases.
REQ-018 If a served walk is still GREEN/flashing, green SHALL NOT exit before timer reaches WALK_T+FLASH_T-1 (walk completes before yellow).
REQ-019 Both latches set simultaneously: each served at its own green in cycle order; no reordering.
REQ-020 Parameters SHALL satisfy GREEN_T >= WALK_T+FLASH_T and MIN_GREEN <= GREEN_T; outputs undefined otherwise.
REQ-021 Timer width SHALL be 8 bits; parameters limited to 1..255.
REQ-022 tick=0 SHALL freeze timer and phase; requests still latch.

Reset
REQ-023 rst=1 at posedge SHALL force phase NS_G, timer 0, latches 0 within the same edge, regardless of tick or current phase.
REQ-024 Reset values: car_ns=0001, car_ew=1000, walk_ns=10, walk_ew=10, ped_wait=00.
REQ-025 Reset mid-phase SHALL abandon the phase with no intermediate yellow.

Configuration
REQ-026 Macro EMERGENCY_PREEMPT_EN defined: emergency=1 in any G or L phase SHALL force exit to that approach's Y2 on the next tick, then enter PREEMPT (all car RED, all walk RED, latches kept) held while emergency=1; on emergency=0 the FSM SHALL enter AR2 then resume at NS_G; emergency during Y/AR phases completes them normally then enters PREEMPT.
REQ-027 Macro undefined: emergency port present but ignored; no PREEMPT state synthesized.

Verification
REQ-028 Reset, tick every cycle, no requests -> NS_G 20 ticks, Y 2, L 10, Y 2, AR 2, EW_G 20..., full period 72 ticks; walk always RED.
REQ-029 ped_req_ew pulse at NS_G timer 3 -> ped_wait=10, NS_G exits at timer 7, EW_G walk_ew GREEN 14 ticks, OFF/GREEN alternation 6 ticks, then RED; ped_wait clears on EW_G entry.
REQ-030 ped_req_ns asserted in AR2->NS_G entry cycle -> ped_wait stays 00, walk_ns GREEN from NS_G timer 0.
REQ-031 tick held 0 for 50 cycles mid-NS_L -> outputs frozen; resumes with remaining LEFT ticks.
REQ-032 rst pulse during EW_L -> next cycle car_ns=0001, car_ew=1000, ped_wait=00.
REQ-033 EMERGENCY_PREEMPT_EN defined, emergency=1 at EW_G timer 5 -> EW_Y2 2 ticks, all RED while held; release -> AR2 2 ticks, NS_G.
